// File: rtl/dbg_display_pkg.sv
// Shared constants for the debug display controller: segment patterns,
// the blank pattern and the channel-select width.
package dbg_display_pkg;

  localparam int unsigned CH_SEL_W = 3;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/dbg_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debouncer
// and a one-cycle step request on each accepted press.
// Optional feature macro: DDU_AUTOREPEAT_EN adds hold-to-repeat steps and
// the level/other_level ports used to suppress steps while both buttons
// are held.
module dbg_debounce #(
  parameter int unsigned DEB_CYC    = 50000,
  parameter int unsigned REPEAT_DLY = 2500000,
  parameter int unsigned REPEAT_PER = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
`ifdef DDU_AUTOREPEAT_EN
  input  logic other_level,
  output logic level,
`endif
  output logic step_req
);

  if (DEB_CYC < 2) begin : g_bad_deb
    $error("dbg_debounce: DEB_CYC must be at least 2");
  end
  if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_rpt
    $error("dbg_debounce: REPEAT_DLY and REPEAT_PER must be at least 1");
  end

  localparam int unsigned DEB_W = $clog2(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic             sync_a;
  logic             sync_b;
  logic             lvl;
  logic [DEB_W-1:0] deb_cnt;
  logic             rise;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after DEB_CYC consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      lvl     <= 1'b0;
    end else if (sync_b == lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      lvl     <= sync_b;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Press is recognised in the same cycle the debounced level goes high.
  always_comb begin
    rise = sync_b && !lvl && (deb_cnt == DEB_LAST);
  end

`ifdef DDU_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_running;
  logic             rpt_fire;

  // First repeat waits REPEAT_DLY, later ones REPEAT_PER.
  always_comb begin
    rpt_fire = lvl && (rpt_cnt == (rpt_running ? PER_LAST : DLY_LAST));
    level    = lvl;
  end

  // Hold-time counter; cleared whenever the debounced level is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt     <= '0;
      rpt_running <= 1'b0;
    end else if (!lvl) begin
      rpt_cnt     <= '0;
      rpt_running <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt     <= '0;
      rpt_running <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  // Step request: press or repeat, suppressed while the other button is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_req <= 1'b0;
    end else begin
      step_req <= (rise || rpt_fire) && !other_level;
    end
  end
`else
  // Step request: one pulse per accepted press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_req <= 1'b0;
    end else begin
      step_req <= rise;
    end
  end
`endif

endmodule

// File: rtl/dbg_display_ctrl.sv
// Board bring-up debug display: button-driven inspection address plus a
// scanned 7-segment view of one selected 32-bit debug channel.
// Optional feature macro: DDU_AUTOREPEAT_EN (hold-to-repeat on inc/dec).
module dbg_display_ctrl
  import dbg_display_pkg::*;
#(
  parameter int unsigned N_DIG       = 8,
  parameter int unsigned N_CH        = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned REFRESH_CYC = 5000,
  parameter int unsigned DEB_CYC     = 50000,
  parameter int unsigned REPEAT_DLY  = 2500000,
  parameter int unsigned REPEAT_PER  = 500000
) (
  input  logic                  clk_5M,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic [CH_SEL_W-1:0]   sel,
  input  logic [N_CH*32-1:0]    ch_data,
  output logic [ADDR_W-1:0]     addr,
  output logic [6:0]            seg,
  output logic [N_DIG-1:0]      an,
  output logic                  addr_step
);

  if (N_DIG < 1 || N_DIG > 8) begin : g_bad_dig
    $error("dbg_display_ctrl: N_DIG must be 1..8");
  end
  if (N_CH < 1 || N_CH > 8) begin : g_bad_ch
    $error("dbg_display_ctrl: N_CH must be 1..8");
  end
  if (REFRESH_CYC < 2 || ADDR_W < 1) begin : g_bad_misc
    $error("dbg_display_ctrl: REFRESH_CYC must be >= 2 and ADDR_W >= 1");
  end

  localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYC - 1);

  logic [CNT_W-1:0]    refresh_cnt;
  logic [IDX_W-1:0]    idx;
  logic [CH_SEL_W-1:0] sel_q;
  logic                scan_live;
  logic [CH_SEL_W-1:0] sel_eff;
  logic [31:0]         word;
  logic [3:0]          nibble;
  logic [N_DIG-1:0]    digit_onehot;
  logic                inc_req;
  logic                dec_req;

  // ---------------------------------------------------------------- buttons
`ifdef DDU_AUTOREPEAT_EN
  logic inc_level;
  logic dec_level;

  dbg_debounce #(
    .DEB_CYC    (DEB_CYC),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc_btn (
    .clk         (clk_5M),
    .rst         (reset),
    .btn         (inc),
    .other_level (dec_level),
    .level       (inc_level),
    .step_req    (inc_req)
  );

  dbg_debounce #(
    .DEB_CYC    (DEB_CYC),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_dec_btn (
    .clk         (clk_5M),
    .rst         (reset),
    .btn         (dec),
    .other_level (inc_level),
    .level       (dec_level),
    .step_req    (dec_req)
  );
`else
  dbg_debounce #(
    .DEB_CYC    (DEB_CYC),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc_btn (
    .clk      (clk_5M),
    .rst      (reset),
    .btn      (inc),
    .step_req (inc_req)
  );

  dbg_debounce #(
    .DEB_CYC    (DEB_CYC),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_dec_btn (
    .clk      (clk_5M),
    .rst      (reset),
    .btn      (dec),
    .step_req (dec_req)
  );
`endif

  // Wrapping address register; opposing requests cancel out.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      addr_step <= 1'b0;
    end else begin
      addr_step <= 1'b0;
      if (inc_req && !dec_req) begin
        addr      <= addr + 1'b1;
        addr_step <= 1'b1;
      end else if (dec_req && !inc_req) begin
        addr      <= addr - 1'b1;
        addr_step <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- scan
  // Refresh timer, digit index and frame-aligned select latch.
  // The first scan after reset samples sel directly, later ones only on wrap.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
      sel_q       <= '0;
      scan_live   <= 1'b0;
    end else begin
      scan_live <= 1'b1;
      if (!scan_live) begin
        sel_q <= sel;
      end
      if (refresh_cnt == CNT_LAST) begin
        refresh_cnt <= '0;
        if (idx == IDX_LAST) begin
          idx   <= '0;
          sel_q <= sel;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // Channel mux; out-of-range selects fall back to channel 0.
  always_comb begin
    sel_eff = scan_live ? sel_q : sel;
    word    = ch_data[31:0];
    for (int unsigned c = 1; c < N_CH; c++) begin
      if (sel_eff == c[CH_SEL_W-1:0]) begin
        word = ch_data[c*32 +: 32];
      end
    end
  end

  // Nibble and one-hot digit for the current index.
  always_comb begin
    nibble       = word[3:0];
    digit_onehot = '0;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (idx == k[IDX_W-1:0]) begin
        nibble          = word[k*4 +: 4];
        digit_onehot[k] = 1'b1;
      end
    end
  end

  // Anode and segment drive registered together so they switch in lockstep.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~digit_onehot;
      seg <= hex_to_seg(nibble);
    end
  end

endmodule
